// File: rtl/step_driver.sv
// step_driver
//   Walks a downstream saturating counter toward a requested value, one
//   increase/decrease strobe every STEP_DIV clocks, and keeps a local mirror
//   of that counter so it knows when the target has been reached.
//
//   Parameters
//     WIDTH     value buses are WIDTH+1 bits wide
//     STEP_DIV  clocks between consecutive strobes (>= 1)
//
//   Ports
//     clk           system clock, rising edge
//     rst           synchronous active-high reset
//     target        requested final counter value
//     target_valid  target offered this cycle
//     target_ready  target accepted on valid && ready at a rising edge
//     increase      one-cycle up-step strobe
//     decrease      one-cycle down-step strobe
//     mirror        tracked copy of the downstream counter
//     busy          high whenever the FSM is not idle
//     done          one-cycle pulse when mirror reaches the latched target
//
//   Build option
//     STEP_DRIVER_RETARGET_EN  also accept a new target while waiting between
//                              strobes; the wait count keeps running and the
//                              direction is re-evaluated at the next step.
//
//   All outputs are registered: next-cycle output values are decoded from the
//   next state, so a strobe is visible in the cycle the FSM sits in STEP and
//   the counter (and mirror) move at the edge that ends that cycle.
module step_driver #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] target,
  input  logic           target_valid,
  output logic           target_ready,
  output logic           increase,
  output logic           decrease,
  output logic [WIDTH:0] mirror,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  // WAIT lasts STEP_DIV-1 cycles; the counter runs 0..STEP_DIV-2.
  localparam int CW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int WLAST = (STEP_DIV > 1) ? STEP_DIV - 2 : 0;
  localparam logic [WIDTH:0] ONE = 1;

  state_t          state_q, state_d;
  logic [WIDTH:0]  tgt_q, tgt_d;
  logic [WIDTH:0]  mir_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inc_d, dec_d, rdy_d, busy_d, done_d;
  logic            accept;

  assign accept = target_valid && target_ready;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;

    // The counter samples the registered strobe at this edge; track it.
    // A strobe is only ever raised toward a strictly larger/smaller target,
    // so the mirror can never step past 0 or the bus maximum.
    mir_d = mirror;
    if (increase)      mir_d = mirror + ONE;
    else if (decrease) mir_d = mirror - ONE;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = target;
          state_d = (target != mirror) ? STEP : DONE;
        end
      end
      STEP: begin
        if (mir_d == tgt_q) begin
          state_d = DONE;
        end else if (STEP_DIV == 1) begin
          state_d = STEP;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
`ifdef STEP_DRIVER_RETARGET_EN
        if (accept) tgt_d = target;
        if (tgt_d == mirror) begin
          state_d = DONE;
        end else
`endif
        if (cnt_q == CW'(WLAST)) begin
          state_d = STEP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Direction is decided on entry to STEP from the current latched target,
    // so a retarget taken during WAIT flips it automatically.
    inc_d  = (state_d == STEP) && (tgt_d > mir_d);
    dec_d  = (state_d == STEP) && (tgt_d < mir_d);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef STEP_DRIVER_RETARGET_EN
    rdy_d  = (state_d == IDLE) || (state_d == WAIT);
`else
    rdy_d  = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      cnt_q        <= '0;
      mirror       <= '0;
      increase     <= 1'b0;
      decrease     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      target_ready <= 1'b1;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      mirror       <= mir_d;
      increase     <= inc_d;
      decrease     <= dec_d;
      busy         <= busy_d;
      done         <= done_d;
      target_ready <= rdy_d;
    end
  end

endmodule

// File: doc/step_driver.md
STEP_DRIVER -- requirements
Module: step_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4; value buses are WIDTH+1 bits wide.
REQ-002 The block SHALL have parameter STEP_DIV, default 4; clock cycles between consecutive step pulses; legal range >= 1.
REQ-003 The block SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have target  input  WIDTH+1  requested final counter value.
REQ-006 The block SHALL have target_valid  input  1  target offered this cycle.
REQ-007 The block SHALL have target_ready  output  1  target accepted when target_valid && target_ready at a rising edge.
REQ-008 The block SHALL have increase  output  1  one-cycle up-step strobe to the saturating counter.
REQ-009 The block SHALL have decrease  output  1  one-cycle down-step strobe to the saturating counter.
REQ-010 The block SHALL have mirror  output  WIDTH+1  tracked copy of the downstream counter value.
REQ-011 The block SHALL have busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have done  output  1  one-cycle pulse when mirror reaches the latched target.

Function
REQ-013 The FSM SHALL have states IDLE, STEP, WAIT and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, target_ready SHALL be 1; on acceptance the target SHALL be latched, and the FSM SHALL go to STEP if target != mirror, else to DONE.
REQ-015 In STEP, exactly one of increase (latched target > mirror) or decrease (latched target < mirror) SHALL be high for one cycle, and mirror SHALL change by 1 at the same edge the counter samples the strobe.
REQ-016 After STEP, the FSM SHALL go to DONE if the updated mirror equals the target; otherwise it SHALL go to WAIT for STEP_DIV-1 cycles (0 cycles when STEP_DIV=1) and then to STEP.
REQ-017 DONE SHALL assert done for exactly one cycle, after which the FSM SHALL go to IDLE.
REQ-018 Timing: with acceptance at cycle 0 and distance d > 0, the k-th strobe SHALL occur at cycle 1+(k-1)*STEP_DIV and done at cycle (d-1)*STEP_DIV+2; with d = 0, done SHALL occur at cycle 1 and no strobe SHALL be issued.
REQ-019 increase and decrease SHALL never be high in the same cycle.
REQ-020 mirror SHALL stay within 0..2^(WIDTH+1)-1; no wrap SHALL occur because the target is bounded by the bus width; a strobe SHALL never be issued at a bound.
REQ-021 A target_valid presented while target_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-022 While rst=1 at a rising edge, the FSM SHALL enter IDLE; mirror, the latched target and the wait counter SHALL be set to 0; increase, decrease, busy and done SHALL be set to 0; target_ready SHALL be set to 1.
REQ-023 rst SHALL take priority over target acceptance and over any step in progress; a reset mid-operation SHALL abort without a done pulse.

Configuration
REQ-024 With STEP_DRIVER_RETARGET_EN defined, target_ready SHALL also be 1 in WAIT; a target accepted there SHALL replace the latched target, the wait count SHALL continue unchanged, and the direction SHALL be re-evaluated at the next STEP; if the new target equals mirror, the FSM SHALL go to DONE on the next cycle.
REQ-025 Without STEP_DRIVER_RETARGET_EN, target_ready SHALL be 1 only in IDLE.

Verification (WIDTH=4, STEP_DIV=4 unless stated)
REQ-026 Up-step: reset, then target=3 accepted at cycle 0 -> increase at cycles 1, 5 and 9; done at cycle 10; mirror=3; busy low from cycle 11.
REQ-027 Zero distance: mirror=3, target=3 -> no strobe; done at cycle 1; mirror stays 3.
REQ-028 Down-step: mirror=3, target=0 -> decrease at cycles 1, 5 and 9; done at cycle 10; mirror=0; increase never high.
REQ-029 Upper bound: STEP_DIV=1, mirror=0, target=31 -> increase high on cycles 1..31; done at cycle 32; mirror=31; no further strobe.
REQ-030 Mid-run reset: target=3, rst=1 at cycle 6 -> from cycle 7, mirror=0, target_ready=1, increase=decrease=done=0; no done pulse.
REQ-031 Retarget: target=10 accepted at cycle 0, target=0 offered at cycle 3 -> macro defined: accepted, decrease at cycle 5, mirror=0, done at cycle 6; macro undefined: target_ready=0 at cycle 3 and the offer stalls until IDLE.
